// File: rtl/matrix_col_scan.sv
// Time-multiplexed LED column scanner with per-slot blanking
// and a double-buffered frame committed only at frame start.
module matrix_col_scan #(
  parameter int NUM_COLS = 5,
  parameter int NUM_ROWS = 7,
  parameter int DWELL    = 50000,
  parameter int BLANK    = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         load,
  input  logic [NUM_COLS*NUM_ROWS-1:0] frame_data,
  output logic [NUM_COLS-1:0]          col_n,
  output logic [NUM_ROWS-1:0]          row,
  output logic [$clog2(NUM_COLS)-1:0]  col_idx,
  output logic                         frame_start,
  output logic                         pending
);

  localparam int IW = $clog2(NUM_COLS);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic                               run;
  logic [IW-1:0]                      idx, idx_d;
  logic [CW-1:0]                      cnt, cnt_d;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0]  disp, pend;
  logic                               pend_f;
  logic                               slot_end, last, commit;

  assign slot_end = (cnt == CW'(DWELL - 1));
  assign last     = (idx == IW'(NUM_COLS - 1));
  // new frame is taken on scan wrap or on scan (re)start
  assign commit   = (run & slot_end & last) | (~run & enable);

  always_comb begin
    idx_d = idx;
    cnt_d = cnt;
    if (!run || !enable) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (slot_end) begin
      cnt_d = '0;
      idx_d = last ? '0 : idx + 1'b1;
    end else begin
      cnt_d = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run    <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      disp   <= '0;
      pend   <= '0;
      pend_f <= 1'b0;
    end else begin
      run <= enable;
      idx <= idx_d;
      cnt <= cnt_d;
      if (commit && pend_f) begin
        disp   <= pend;
        pend_f <= 1'b0;
      end
      // a load on the commit edge refills pend after the old one moved
      if (load) begin
        pend   <= frame_data;
        pend_f <= 1'b1;
      end
    end
  end

  always_comb begin
    col_n = '1;
    row   = '0;
    if (run && (int'(cnt) >= BLANK)) begin
      col_n[idx] = 1'b0;
      row        = disp[idx];
    end
  end

  assign col_idx     = idx;
  assign frame_start = run & (idx == '0) & (cnt == '0);
  assign pending     = pend_f;

endmodule
